// File: rtl/regfile_dump_reader.sv
// Walks a range of RV32 integer registers through a dedicated read port and streams (index, value) beats.
// Optional running checksum of accepted beats when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              busy,
   output logic              stall_req,
`ifdef REGDUMP_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
   logic [DATA_W-1:0] dump_data_q, dump_data_d;
   logic              dump_valid_q, dump_valid_d;
   logic              done_q, done_d;
   logic              hs;
   logic              at_last;
   logic [ADDR_W-1:0] addr_inc;
`ifdef REGDUMP_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

   assign hs       = (state_q == S_SEND) && dump_valid_q && dump_ready;
   assign at_last  = (dump_addr_q == last_q);
   assign addr_inc = (rf_addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : rf_addr_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         last_q       <= '0;
         rf_addr_q    <= '0;
         dump_addr_q  <= '0;
         dump_data_q  <= '0;
         dump_valid_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         checksum_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         rf_addr_q    <= rf_addr_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         dump_valid_q <= dump_valid_d;
         done_q       <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   // Next state and datapath; abort overrides every transition, including the final handshake.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      rf_addr_d    = rf_addr_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      dump_valid_d = dump_valid_q;
`ifdef REGDUMP_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               last_d    = last_reg;
               rf_addr_d = first_reg;
               state_d   = S_READ;
`ifdef REGDUMP_CHECKSUM_EN
               checksum_d = '0;
`endif
            end
         end
         S_READ: begin
            dump_data_d  = rf_data;
            dump_addr_d  = rf_addr_q;
            dump_valid_d = 1'b1;
            state_d      = S_SEND;
         end
         S_SEND: begin
            if (hs) begin
               dump_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
               checksum_d   = checksum_q + dump_data_q;
`endif
               if (at_last) begin
                  state_d = S_DONE;
               end else begin
                  rf_addr_d = addr_inc;
                  state_d   = S_READ;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d      = S_IDLE;
         dump_valid_d = 1'b0;
      end
      done_d = (state_d == S_DONE);
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      stall_req  = busy;
      rf_addr    = rf_addr_q;
      dump_valid = dump_valid_q;
      dump_addr  = dump_addr_q;
      dump_data  = dump_data_q;
      done       = done_q;
`ifdef REGDUMP_CHECKSUM_EN
      checksum   = checksum_q;
`endif
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected beats queued by stimulus, popped by a negedge monitor.
module tb_regfile_dump_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [4:0]  first_reg = '0;
   logic [4:0]  last_reg = '0;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        dump_valid;
   logic        dump_ready = 1'b0;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;
   logic        busy;
   logic        stall_req;
   logic        done;
`ifdef REGDUMP_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   logic [31:0] rf [32];
   assign rf_data = rf[rf_addr];

   always #5 clk = ~clk;

   regfile_dump_reader dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_reg(first_reg), .last_reg(last_reg),
      .rf_addr(rf_addr), .rf_data(rf_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_addr(dump_addr), .dump_data(dump_data),
      .busy(busy), .stall_req(stall_req),
`ifdef REGDUMP_CHECKSUM_EN
      .checksum(checksum),
`endif
      .done(done)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } beat_t;

   beat_t exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic prev_hs = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push_range(input int f, input int l);
      int i;
      i = f;
      forever begin
         exp_q.push_back('{a: 5'(i), d: rf[i]});
         if (i == l) break;
         i = (i + 1) % 32;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [4:0] f, input logic [4:0] l);
      first_reg = f;
      last_reg  = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", {31'd0, seen}, 32'd1);
      tick();
   endtask

   task automatic monitor();
      beat_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (dump_valid && dump_ready) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_beat: got addr=%0d data=%h, required no beat", dump_addr, dump_data);
               end else begin
                  e = exp_q.pop_front();
                  if (dump_addr !== e.a || dump_data !== e.d) begin
                     n_bad++;
                     $display("FAIL beat: got addr=%0d data=%h, required addr=%0d data=%h",
                              dump_addr, dump_data, e.a, e.d);
                  end else begin
                     $display("beat addr=%0d data=%h", dump_addr, dump_data);
                  end
               end
            end
            if (done) begin
               done_cnt++;
               check("done_after_last_beat", {31'd0, prev_hs}, 32'd1);
            end
            prev_hs = dump_valid && dump_ready;
         end else begin
            prev_hs = 1'b0;
         end
      end
   endtask

   task automatic stimulus();
      logic [31:0] sum;
      logic        seen;

      for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11;

      #2 reset = 1'b0;
      #1;
      check("reset_rf_addr", {27'd0, rf_addr}, 32'd0);
      check("reset_dump_addr", {27'd0, dump_addr}, 32'd0);
      check("reset_dump_data", dump_data, 32'd0);
      check("reset_outputs", {28'd0, dump_valid, busy, stall_req, done}, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Full dump 0..31 with latency check
      dump_ready = 1'b1;
      push_range(0, 31);
      do_start(5'd0, 5'd31);
      check("latency_read", {31'd0, dump_valid}, 32'd0);
      check("busy_in_read", {30'd0, busy, stall_req}, 32'd3);
      tick();
      check("latency_send", {31'd0, dump_valid}, 32'd1);
      wait_done(200);
      exp_done++;
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("done_count_full", done_cnt, exp_done);
      check("queue_empty_full", exp_q.size(), 0);
`ifdef REGDUMP_CHECKSUM_EN
      sum = '0;
      for (int i = 0; i < 32; i++) sum = sum + rf[i];
      check("checksum_full", checksum, sum);
`else
      sum = '0;
`endif

      // Wrap 30..1
      push_range(30, 1);
      do_start(5'd30, 5'd1);
      wait_done(50);
      exp_done++;
      check("done_count_wrap", done_cnt, exp_done);
      check("queue_empty_wrap", exp_q.size(), 0);

      // Backpressure on a single-register dump
      rf[3] = 32'h1;
      dump_ready = 1'b0;
      push_range(3, 3);
      do_start(5'd3, 5'd3);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (dump_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check("bp_valid_seen", {31'd0, seen}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid_hold", {31'd0, dump_valid}, 32'd1);
         check("bp_addr_hold", {27'd0, dump_addr}, 32'd3);
         check("bp_data_hold", dump_data, 32'h1);
         tick();
      end
      dump_ready = 1'b1;
      wait_done(10);
      exp_done++;
      check("done_count_bp", done_cnt, exp_done);
      check("queue_empty_bp", exp_q.size(), 0);
      rf[3] = 32'h33;

      // Abort during SEND of the third beat
      push_range(0, 2);
      do_start(5'd0, 5'd31);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (dump_valid && dump_addr == 5'd2) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check("abort_third_beat_seen", {31'd0, seen}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", {30'd0, busy, dump_valid}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("abort_no_done", done_cnt, exp_done);
      check("queue_empty_abort", exp_q.size(), 0);

      // Abort and start together in IDLE: stays idle
      abort = 1'b1;
      do_start(5'd7, 5'd7);
      abort = 1'b0;
      check("abort_beats_start", {31'd0, busy}, 32'd0);

      push_range(5, 5);
      do_start(5'd5, 5'd5);
      wait_done(10);
      exp_done++;
      check("done_count_after_abort", done_cnt, exp_done);

      // Start while busy is ignored
      push_range(10, 12);
      do_start(5'd10, 5'd12);
      tick();
      do_start(5'd20, 5'd25);
      wait_done(30);
      exp_done++;
      check("done_count_busy_start", done_cnt, exp_done);
      check("queue_empty_busy_start", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) tick();
      check("no_restart", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-dump
      push_range(0, 31);
      do_start(5'd0, 5'd31);
      for (int i = 0; i < 6; i++) tick();
      #2 reset = 1'b0;
      #1;
      check("async_rst_outputs", {28'd0, dump_valid, busy, stall_req, done}, 32'd0);
      check("async_rst_data", dump_data, 32'd0);
      check("async_rst_addr", {22'd0, dump_addr, rf_addr}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("post_reset_idle", {30'd0, busy, dump_valid}, 32'd0);
      check("post_reset_done", done_cnt, exp_done);
      if (sum == 32'hFFFF_FFFF) $display("note: unusual checksum");
   endtask

   initial begin
      fork
         monitor();
         stimulus();
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
